// File: rtl/matmul_tile_sequencer_pkg.sv
// Shared definitions for the 3x3 tiled matrix-multiply sequencer.
//   TILE       : tile edge length; every matrix dimension must be a multiple of it
//   OP_A/OP_B  : operand select values for matrix_manager's column input
//   state_e    : 3-bit controller state encoding
package matmul_tile_sequencer_pkg;

  localparam int TILE = 3;

  localparam logic OP_A = 1'b0;
  localparam logic OP_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_A   = 3'd1,
    ST_LOAD_B   = 3'd2,
    ST_MAC      = 3'd3,
    ST_WAIT_MAC = 3'd4,
    ST_WRITE    = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/matmul_tile_sequencer_tile_index_counter.sv
// Nested tile index counter for the matmul sequencer: k is the inner
// (reduction) index, j walks C tile columns fastest, i walks C tile rows.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   clear                 : zero all indices (job accepted)
//   k_inc / k_clr         : advance k / return k to 0 after the last k
//   tile_adv              : step to the next output tile (j fastest)
//   nt, mt, pt            : tile counts along n, m, p
//   tile_i/j/k            : current indices
//   is_last_k, is_last_tile : k == mt-1, (i,j) == (nt-1, pt-1)
module tile_index_counter
  import matmul_tile_sequencer_pkg::*;
#(
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             k_inc,
  input  logic             k_clr,
  input  logic             tile_adv,
  input  logic [IDX_W-1:0] nt,
  input  logic [IDX_W-1:0] mt,
  input  logic [IDX_W-1:0] pt,
  output logic [IDX_W-1:0] tile_i,
  output logic [IDX_W-1:0] tile_j,
  output logic [IDX_W-1:0] tile_k,
  output logic             is_last_k,
  output logic             is_last_tile
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  // NOTE: non-blocking assignments, so every flop here samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tile_i <= '0;
      tile_j <= '0;
      tile_k <= '0;
    end else begin
      if (k_inc) tile_k <= tile_k + ONE;
      if (k_clr) tile_k <= '0;
      if (tile_adv) begin
        if (tile_j < pt - ONE) begin
          tile_j <= tile_j + ONE;
        end else begin
          tile_j <= '0;
          // On the final tile i saturates; the job ends there anyway.
          if (tile_i < nt - ONE) tile_i <= tile_i + ONE;
        end
      end
    end
  end

  assign is_last_k    = (tile_k == mt - ONE);
  assign is_last_tile = (tile_i == nt - ONE) && (tile_j == pt - ONE);

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Control FSM computing C = A*B one 3x3 tile at a time through matrix_manager
// and a 3x3 MAC unit. Per output tile (i,j) it loops k: load A tile, load B
// tile, start MAC, wait for mac_done; after the last k it writes C back.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, n, m, p    : job request and matrix dims (A n x m, B m x p)
//   mac_done          : MAC finished the current tile product
//   busy, done, err   : status; done/err are one-cycle pulses
//   mm_column, mm_next_row, mm_dm_we : matrix_manager controls
//   latch_a, latch_b, acc_clear, mac_start : MAC datapath controls
//   tile_i, tile_j, tile_k : current tile indices
module matmul_tile_sequencer
  import matmul_tile_sequencer_pkg::*;
#(
  parameter int DIM_W = 10,
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] n,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] p,
  input  logic             mac_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mm_column,
  output logic             mm_next_row,
  output logic             mm_dm_we,
  output logic             latch_a,
  output logic             latch_b,
  output logic             acc_clear,
  output logic             mac_start,
  output logic [IDX_W-1:0] tile_i,
  output logic [IDX_W-1:0] tile_j,
  output logic [IDX_W-1:0] tile_k
);

  localparam logic [DIM_W-1:0] TILE_D = DIM_W'(TILE);

  state_e           state, state_next;
  logic [IDX_W-1:0] nt, mt, pt;
  logic             err_next, accept, k_inc, k_clr, tile_adv;
  logic             is_last_k, is_last_tile;
  logic             dims_ok;

  assign dims_ok = (n != '0) && (m != '0) && (p != '0) &&
                   ((n % TILE_D) == '0) && ((m % TILE_D) == '0) &&
                   ((p % TILE_D) == '0);

  // Tile counts are divided once on acceptance and held for the whole job.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      err   <= 1'b0;
      nt    <= '0;
      mt    <= '0;
      pt    <= '0;
    end else begin
      state <= state_next;
      err   <= err_next;
      if (accept) begin
        nt <= IDX_W'(n / TILE_D);
        mt <= IDX_W'(m / TILE_D);
        pt <= IDX_W'(p / TILE_D);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    err_next    = 1'b0;
    accept      = 1'b0;
    k_inc       = 1'b0;
    k_clr       = 1'b0;
    tile_adv    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mm_column   = OP_A;
    mm_next_row = 1'b0;
    mm_dm_we    = 1'b0;
    latch_a     = 1'b0;
    latch_b     = 1'b0;
    acc_clear   = 1'b0;
    mac_start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            accept     = 1'b1;
            state_next = ST_LOAD_A;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_LOAD_A: begin
        busy        = 1'b1;
        mm_column   = OP_A;
        mm_next_row = 1'b1;
        latch_a     = 1'b1;
        acc_clear   = (tile_k == '0);
        state_next  = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        busy        = 1'b1;
        mm_column   = OP_B;
        mm_next_row = 1'b1;
        latch_b     = 1'b1;
        state_next  = ST_MAC;
      end
      ST_MAC: begin
        busy       = 1'b1;
        mac_start  = 1'b1;
        state_next = ST_WAIT_MAC;
      end
      ST_WAIT_MAC: begin
        busy = 1'b1;
        if (mac_done) begin
          if (is_last_k) begin
            k_clr      = 1'b1;
            state_next = ST_WRITE;
          end else begin
            k_inc      = 1'b1;
            state_next = ST_LOAD_A;
          end
        end
      end
      ST_WRITE: begin
        busy        = 1'b1;
        mm_dm_we    = 1'b1;
        mm_next_row = 1'b1;
        tile_adv    = 1'b1;
        state_next  = is_last_tile ? ST_DONE : ST_LOAD_A;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  tile_index_counter #(.IDX_W(IDX_W)) u_idx (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept),
    .k_inc        (k_inc),
    .k_clr        (k_clr),
    .tile_adv     (tile_adv),
    .nt           (nt),
    .mt           (mt),
    .pt           (pt),
    .tile_i       (tile_i),
    .tile_j       (tile_j),
    .tile_k       (tile_k),
    .is_last_k    (is_last_k),
    .is_last_tile (is_last_tile)
  );

endmodule
